// File: rtl/tpu_c_port.sv
// -----------------------------------------------------------------------------
// tpu_c_port
//   MMIO bridge for the systolic array's C accumulator matrix (window
//   0x0300-0x037F). The array moves whole rows (DIM x BITS_C bits) only, so
//   host 64-bit reads return one slice of a fetched row, and host writes
//   fetch the row, splice in the new slice and write the whole row back.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req, r_w          one-cycle host strobe, 0 = read / 1 = write
//   addr, dataIn      host byte address and write data
//   ready             request accepted this cycle (combinational)
//   dataOut, rd_valid read data and its one-cycle strobe
//   mm_busy           array busy; blocks new accesses
//   Crow              row select to the array (registered)
//   Cout              row read data from the array (combinational from Crow)
//   Cin, WrEnC        row write data (registered) and one-cycle write strobe
// -----------------------------------------------------------------------------
module tpu_c_port #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8,
  parameter int ADDRW  = 16,
  parameter int DATAW  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    r_w,
  input  logic [ADDRW-1:0]        addr,
  input  logic [DATAW-1:0]        dataIn,
  output logic                    ready,
  output logic [DATAW-1:0]        dataOut,
  output logic                    rd_valid,
  input  logic                    mm_busy,
  output logic [$clog2(DIM)-1:0]  Crow,
  input  logic [DIM*BITS_C-1:0]   Cout,
  output logic [DIM*BITS_C-1:0]   Cin,
  output logic                    WrEnC
);

  localparam int ROWW = DIM * BITS_C;
  localparam int WPR  = ROWW / DATAW;
  localparam int RW   = $clog2(DIM);
  localparam int HW   = (WPR > 1) ? $clog2(WPR) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, RRESP, WBACK} state_t;

  state_t            state;
  logic [HW-1:0]     half_q;
  logic              wr_q;
  logic [DATAW-1:0]  data_q;

  // Address decode: byte offset bits are ignored, then half-select, then row.
  logic              hit;
  logic [RW-1:0]     row;
  logic [HW-1:0]     half;
  logic              accept;
  logic              unused_addr_bits;

  assign hit    = (addr[ADDRW-1:8] == (ADDRW-8)'(8'h03)) && !addr[7];
  assign row    = addr[3+HW +: RW];
  assign half   = addr[3 +: HW];
  assign ready  = (state == IDLE) && !mm_busy;
  assign accept = req && ready && hit;
  assign unused_addr_bits = ^addr[2:0];

  // Row with the latched slice replaced by the latched host data.
  logic [ROWW-1:0] merged;

  // NOTE: every always_comb output gets a full default first so no latch is
  // inferred when a branch or part-select leaves bits unassigned.
  always_comb begin
    merged = Cout;
    merged[int'(half_q)*DATAW +: DATAW] = data_q;
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      Crow     <= '0;
      Cin      <= '0;
      dataOut  <= '0;
      rd_valid <= 1'b0;
      WrEnC    <= 1'b0;
      half_q   <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            Crow   <= row;
            half_q <= half;
            wr_q   <= r_w;
            data_q <= dataIn;
            state  <= FETCH;
          end
        end
        // Cout is valid for the row selected on accept.
        FETCH: begin
          if (wr_q) begin
            Cin   <= merged;
            WrEnC <= 1'b1;
            state <= WBACK;
          end else begin
            dataOut  <= Cout[int'(half_q)*DATAW +: DATAW];
            rd_valid <= 1'b1;
            state    <= RRESP;
          end
        end
        RRESP: begin
          rd_valid <= 1'b0;
          state    <= IDLE;
        end
        WBACK: begin
          WrEnC <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_c_port.sv
// -----------------------------------------------------------------------------
// tb_tpu_c_port
//   Directed bench for tpu_c_port. A small array model answers Crow/Cout and
//   applies WrEnC writes; expected read data and row writes are queued when
//   stimulus is issued and compared by a monitor when the DUT responds.
// -----------------------------------------------------------------------------
module tb_tpu_c_port;

  localparam int BITS_C = 16;
  localparam int DIM    = 8;
  localparam int ROWW   = DIM * BITS_C;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req;
  logic              r_w;
  logic [15:0]       addr;
  logic [63:0]       dataIn;
  logic              ready;
  logic [63:0]       dataOut;
  logic              rd_valid;
  logic              mm_busy;
  logic [2:0]        Crow;
  logic [ROWW-1:0]   Cout;
  logic [ROWW-1:0]   Cin;
  logic              WrEnC;

  tpu_c_port #(.BITS_C(BITS_C), .DIM(DIM), .ADDRW(16), .DATAW(64)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .r_w(r_w), .addr(addr),
    .dataIn(dataIn), .ready(ready), .dataOut(dataOut), .rd_valid(rd_valid),
    .mm_busy(mm_busy), .Crow(Crow), .Cout(Cout), .Cin(Cin), .WrEnC(WrEnC)
  );

  always #5 clk = ~clk;

  // Array model: combinational row read, row write on WrEnC, bench preload.
  logic [ROWW-1:0] mem [DIM];
  logic            pl_en = 1'b0;
  logic [2:0]      pl_row = '0;
  logic [ROWW-1:0] pl_data = '0;

  assign Cout = mem[Crow];

  always @(posedge clk) begin
    if (WrEnC)      mem[Crow]   <= Cin;
    else if (pl_en) mem[pl_row] <= pl_data;
  end

  int n_assert = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;

  typedef struct {
    logic [2:0]      row;
    logic [ROWW-1:0] data;
  } wr_exp_t;

  logic [63:0] exp_rd [$];
  wr_exp_t     exp_wr [$];

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      rd_cnt++;
      check("rd_pending", 128'(exp_rd.size() > 0), 128'd1);
      if (exp_rd.size() > 0) check("rd_data", dataOut, exp_rd.pop_front());
    end
    if (rst_n && WrEnC) begin
      wr_cnt++;
      check("wr_pending", 128'(exp_wr.size() > 0), 128'd1);
      if (exp_wr.size() > 0) begin
        wr_exp_t e;
        e = exp_wr.pop_front();
        check("wr_row", Crow, e.row);
        check("wr_data", Cin, e.data);
      end
    end
  end

  task automatic preload(input logic [2:0] r, input logic [ROWW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_row = r; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One accepted access with cycle-by-cycle handshake checks.
  task automatic access(input logic w, input logic [15:0] a,
                        input logic [63:0] d);
    @(negedge clk);
    check("ready_c0", ready, 1);
    req = 1'b1; r_w = w; addr = a; dataIn = d;
    @(negedge clk);
    req = 1'b0;
    check("ready_c1", ready, 0);
    @(negedge clk);
    check(w ? "wren_c2" : "rdv_c2", w ? WrEnC : rd_valid, 1);
    check("ready_c2", ready, 0);
    @(negedge clk);
    check("ready_c3", ready, 1);
    check(w ? "wren_c3" : "rdv_c3", w ? WrEnC : rd_valid, 0);
  endtask

  task automatic push_wr(input logic [2:0] r, input logic [ROWW-1:0] d);
    wr_exp_t e;
    e.row = r; e.data = d;
    exp_wr.push_back(e);
  endtask

  localparam logic [63:0] ROW0_HI = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] ROW0_LO = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] ONES    = 64'h1111_1111_1111_1111;
  localparam logic [63:0] ROW1_LO = 64'h0102_0304_0506_0708;
  localparam logic [63:0] ROW1_HI = 64'h5555_6666_7777_8888;
  localparam logic [127:0] ROW2   = 128'hA5A5_0F0F_3C3C_9999_4242_1357_2468_BDBD;

  initial begin
    int rd0, wr0;
    rst_n = 1'b0; req = 1'b0; r_w = 1'b0; addr = '0; dataIn = '0; mm_busy = 1'b0;
    for (int i = 0; i < DIM; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wrenc", WrEnC, 0);
    check("rst_crow", Crow, 0);
    check("rst_dataout", dataOut, 0);
    check("rst_cin", Cin, 0);

    // Low-half write to row 0, then read both halves back.
    preload(3'd0, {ROW0_HI, ROW0_LO});
    push_wr(3'd0, {ROW0_HI, 64'h0004_0003_0002_0001});
    access(1'b1, 16'h0300, 64'h0004_0003_0002_0001);
    exp_rd.push_back(64'h0004_0003_0002_0001);
    access(1'b0, 16'h0300, '0);
    exp_rd.push_back(ROW0_HI);
    access(1'b0, 16'h030D, '0);   // byte offset bits ignored
    check("dataout_hold", dataOut, ROW0_HI);

    // High-half write to row 7 with boundary element values.
    preload(3'd7, {ONES, ONES});
    push_wr(3'd7, {64'hFFFF_8000_7FFF_0000, ONES});
    access(1'b1, 16'h0378, 64'hFFFF_8000_7FFF_0000);
    exp_rd.push_back(64'hFFFF_8000_7FFF_0000);
    access(1'b0, 16'h0378, '0);
    exp_rd.push_back(ONES);
    access(1'b0, 16'h0370, '0);

    // mm_busy blocks a read at 0x0310; retry after it drops.
    preload(3'd1, {ROW1_HI, ROW1_LO});
    @(negedge clk);
    mm_busy = 1'b1; req = 1'b1; r_w = 1'b0; addr = 16'h0310;
    #1 check("busy_ready", ready, 0);
    @(negedge clk);
    req = 1'b0;
    check("busy_rdv1", rd_valid, 0);
    @(negedge clk);
    check("busy_rdv2", rd_valid, 0);
    check("busy_crow", Crow, 7);
    mm_busy = 1'b0;
    exp_rd.push_back(ROW1_LO);
    access(1'b0, 16'h0310, '0);

    // Out-of-range requests and back-to-back requests during an access.
    @(posedge clk);
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(negedge clk);
    req = 1'b1; r_w = 1'b0; addr = 16'h0380;
    @(negedge clk); r_w = 1'b1; addr = 16'h0400; dataIn = '1;
    @(negedge clk); r_w = 1'b0; addr = 16'h0200;
    @(negedge clk); r_w = 1'b1; addr = 16'h0380;
    @(negedge clk); req = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    check("oor_rd_cnt", rd_cnt, rd0);
    check("oor_wr_cnt", wr_cnt, wr0);
    check("oor_crow", Crow, 1);

    exp_rd.push_back(ROW1_HI);
    @(negedge clk);
    req = 1'b1; r_w = 1'b0; addr = 16'h0318;          // accepted
    @(negedge clk); r_w = 1'b1; addr = 16'h0310; dataIn = '0;  // ignored
    @(negedge clk); addr = 16'h0300;                  // ignored
    @(negedge clk); req = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    check("b2b_rd_cnt", rd_cnt, rd0 + 1);
    check("b2b_wr_cnt", wr_cnt, wr0);
    check("b2b_row1", mem[1], {ROW1_HI, ROW1_LO});

    // Reset during FETCH of a write: no row write, outputs cleared.
    preload(3'd2, ROW2);
    @(posedge clk);
    wr0 = wr_cnt;
    @(negedge clk);
    req = 1'b1; r_w = 1'b1; addr = 16'h0328; dataIn = 64'hBAD0_BAD1_BAD2_BAD3;
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rrst_wrenc", WrEnC, 0);
    check("rrst_crow", Crow, 0);
    check("rrst_cin", Cin, 0);
    check("rrst_dataout", dataOut, 0);
    check("rrst_rd_valid", rd_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    check("rrst_wr_cnt", wr_cnt, wr0);
    check("rrst_row2", mem[2], ROW2);
    check("rrst_ready", ready, 1);

    check("rd_q_empty", exp_rd.size(), 0);
    check("wr_q_empty", exp_wr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
